writeback_stage: RTL and testbench

- Final pipeline stage: holds the MEM/WB pipeline register and selects the writeback value (ALU result, aligned load data or PC+4).
- Drives the register-file write port consumed by decode (wb_rd, wb_data, wb_regwen).
- Waits for variable-latency load responses with a timeout, back-pressuring the memory stage while it waits.
- Counts retired instructions.

---
 rtl/writeback_stage_if.sv | 26 ++
 rtl/writeback_stage.sv | 134 +++++++++++++
 tb/tb_writeback_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bus: instruction handshake plus the load response channel.
// The memory stage is the master; the writeback stage is the slave and returns in_ready.
interface writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_regwen;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_load_type;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    output in_valid, in_pc, in_alu_result, in_rd, in_regwen, in_wb_sel, in_load_type,
    output mem_rsp_valid, mem_rsp_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_alu_result, in_rd, in_regwen, in_wb_sel, in_load_type,
    input  mem_rsp_valid, mem_rsp_data,
    output in_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the writeback value, waits (with timeout) for load data,
// drives the register-file write port and counts retired instructions.
module writeback_stage #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 64
) (
  input  logic               clk,
  input  logic               reset,
  writeback_stage_if.slave   bus,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               wb_regwen,
  output logic               retire,
  output logic               load_err,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e             state_q;
  logic [4:0]         rd_q;
  logic               regwen_q;
  logic [2:0]         lt_q;
  logic [1:0]         off_q;
  logic [7:0]         cnt_q;
  logic [4:0]         wb_rd_q;
  logic [31:0]        wb_data_q;
  logic               wb_regwen_q;
  logic               retire_q;
  logic               load_err_q;
  logic [CNT_W-1:0]   instret_q;

  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic [31:0]        load_val;
  logic               load_ok;

  assign bus.in_ready = (state_q == StIdle);
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_regwen    = wb_regwen_q;
  assign retire       = retire_q;
  assign load_err     = load_err_q;
  assign instret      = instret_q;

  // Extract the addressed byte/halfword from the aligned response word.
  always_comb begin
    load_ok  = 1'b1;
    load_val = '0;
    case (off_q)
      2'd0:    byte_v = bus.mem_rsp_data[7:0];
      2'd1:    byte_v = bus.mem_rsp_data[15:8];
      2'd2:    byte_v = bus.mem_rsp_data[23:16];
      default: byte_v = bus.mem_rsp_data[31:24];
    endcase
    half_v = off_q[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
    case (lt_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'h0, half_v};
      3'b010:  load_val = bus.mem_rsp_data;
      default: load_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_q        <= '0;
      regwen_q    <= 1'b0;
      lt_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_regwen_q <= 1'b0;
      retire_q    <= 1'b0;
      load_err_q  <= 1'b0;
      instret_q   <= '0;
    end else begin
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_regwen_q <= 1'b0;
      retire_q    <= 1'b0;
      load_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            if (bus.in_wb_sel == 2'b01) begin
              rd_q     <= bus.in_rd;
              regwen_q <= bus.in_regwen;
              lt_q     <= bus.in_load_type;
              off_q    <= bus.in_alu_result[1:0];
              cnt_q    <= '0;
              state_q  <= StWaitMem;
            end else begin
              retire_q    <= 1'b1;
              instret_q   <= instret_q + CNT_W'(1);
              wb_rd_q     <= bus.in_rd;
              wb_regwen_q <= bus.in_regwen && (bus.in_rd != 5'd0) && (bus.in_wb_sel != 2'b11);
              case (bus.in_wb_sel)
                2'b00:   wb_data_q <= bus.in_alu_result;
                2'b10:   wb_data_q <= bus.in_pc + 32'd4;
                default: wb_data_q <= '0;
              endcase
            end
          end
        end
        StWaitMem: begin
          // A response arriving in the final wait cycle takes priority over the timeout.
          if (bus.mem_rsp_valid) begin
            retire_q    <= 1'b1;
            instret_q   <= instret_q + CNT_W'(1);
            wb_rd_q     <= rd_q;
            wb_data_q   <= load_ok ? load_val : 32'h0;
            wb_regwen_q <= regwen_q && (rd_q != 5'd0) && load_ok;
            load_err_q  <= !load_ok;
            state_q     <= StIdle;
          end else if (cnt_q == TimeoutLast) begin
            load_err_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes expected writebacks, a negedge
// monitor pops and compares whenever the stage retires or flags a load error.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_regwen;
  logic        retire;
  logic        load_err;
  logic [63:0] instret;

  writeback_stage_if bus ();

  writeback_stage #(
    .MEM_TIMEOUT (4),
    .CNT_W       (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_regwen (wb_regwen),
    .retire    (retire),
    .load_err  (load_err),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        regwen;
    logic        ret;
    logic        err;
    logic [63:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_cnt = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input logic regwen,
                          input logic ret, input logic err);
    exp_t e;
    if (ret) exp_cnt = exp_cnt + 64'd1;
    e.rd = rd; e.data = data; e.regwen = regwen; e.ret = ret; e.err = err; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (retire === 1'b1 || load_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: retire=%b load_err=%b wb_rd=%0d wb_data=%h",
                 retire, load_err, wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", 64'(wb_data), 64'(e.data));
        chk("wb_regwen", 64'(wb_regwen), 64'(e.regwen));
        chk("retire", 64'(retire), 64'(e.ret));
        chk("load_err", 64'(load_err), 64'(e.err));
        chk("instret", instret, e.cnt);
      end
    end else if (wb_regwen === 1'b1) begin
      total++;
      bad++;
      $display("FAIL stray_regwen: wb_regwen=1 without retire");
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                       input logic regwen, input logic [1:0] sel, input logic [2:0] lt);
    chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid      = 1'b1;
    bus.in_pc         = pc;
    bus.in_alu_result = alu;
    bus.in_rd         = rd;
    bus.in_regwen     = regwen;
    bus.in_wb_sel     = sel;
    bus.in_load_type  = lt;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Load accepted, `waits` idle cycles, then response on the following cycle.
  task automatic do_load(input logic [2:0] lt, input logic [1:0] off, input logic [4:0] rd,
                         input int waits, input logic [31:0] rsp, input logic [31:0] exp_data,
                         input logic exp_regwen, input logic exp_err);
    drive(32'h100, {30'h0400_0000, off}, rd, 1'b1, 2'b01, lt);
    for (int i = 0; i < waits; i++) begin
      chk("in_ready_wait", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd0);
    push_exp(rd, exp_data, exp_regwen, 1'b1, exp_err);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = rsp;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    chk("in_ready_after_load", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_alu_result = '0; bus.in_rd = '0;
    bus.in_regwen = 1'b0; bus.in_wb_sel = '0; bus.in_load_type = '0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;

    // Reset held 3 cycles with a valid instruction presented.
    reset = 1'b0;
    bus.in_valid = 1'b1; bus.in_rd = 5'd5; bus.in_regwen = 1'b1; bus.in_alu_result = 32'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_regwen", 64'(wb_regwen), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // ALU ops, x0 target, JAL wrap, reserved select, then a back-to-back pair.
    push_exp(5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 32'hDEADBEEF, 5'd5, 1'b1, 2'b00, 3'b000);
    push_exp(5'd0, 32'h12345678, 1'b0, 1'b1, 1'b0);
    drive(32'h0, 32'h12345678, 5'd0, 1'b1, 2'b00, 3'b000);
    @(posedge clk); #1;
    push_exp(5'd1, 32'h00000000, 1'b1, 1'b1, 1'b0);
    drive(32'hFFFFFFFC, 32'h0, 5'd1, 1'b1, 2'b10, 3'b000);
    push_exp(5'd3, 32'h00000000, 1'b0, 1'b1, 1'b0);
    drive(32'h40, 32'hAAAA5555, 5'd3, 1'b1, 2'b11, 3'b000);
    push_exp(5'd7, 32'h00001004, 1'b1, 1'b1, 1'b0);
    drive(32'h1000, 32'h0, 5'd7, 1'b1, 2'b10, 3'b000);
    push_exp(5'd8, 32'h0BADF00D, 1'b0, 1'b1, 1'b0);
    drive(32'h0, 32'h0BADF00D, 5'd8, 1'b0, 2'b00, 3'b000);

    // Loads against rsp=0x8081F2F3, response on the third cycle after accept.
    do_load(3'b000, 2'd1, 5'd10, 2, 32'h8081F2F3, 32'hFFFFFFF2, 1'b1, 1'b0);
    do_load(3'b100, 2'd3, 5'd11, 2, 32'h8081F2F3, 32'h00000080, 1'b1, 1'b0);
    do_load(3'b001, 2'd2, 5'd12, 2, 32'h8081F2F3, 32'hFFFF8081, 1'b1, 1'b0);
    do_load(3'b101, 2'd0, 5'd13, 2, 32'h8081F2F3, 32'h0000F2F3, 1'b1, 1'b0);
    do_load(3'b010, 2'd3, 5'd14, 2, 32'h8081F2F3, 32'h8081F2F3, 1'b1, 1'b0);
    do_load(3'b001, 2'd1, 5'd15, 0, 32'h8081F2F3, 32'hFFFFF2F3, 1'b1, 1'b0);

    // Timeout: four wait cycles without response, then a bare load_err pulse.
    drive(32'h100, 32'h2000, 5'd9, 1'b1, 2'b01, 3'b010);
    push_exp(5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("in_ready_timeout", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("in_ready_after_timeout", 64'(bus.in_ready), 64'd1);

    // Response in the last permitted cycle wins over the timeout.
    do_load(3'b010, 2'd0, 5'd16, 3, 32'hCAFEBABE, 32'hCAFEBABE, 1'b1, 1'b0);

    // Bad load type still retires but flags an error.
    do_load(3'b011, 2'd0, 5'd17, 1, 32'h8081F2F3, 32'h00000000, 1'b0, 1'b1);

    // Reset in the middle of a wait drops the load; a later response is ignored.
    drive(32'h100, 32'h3000, 5'd18, 1'b1, 2'b01, 3'b010);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_cnt = 64'd0;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_instret", instret, exp_cnt);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h55555555;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    chk("ignored_rsp_retire", 64'(retire), 64'd0);
    chk("ignored_rsp_regwen", 64'(wb_regwen), 64'd0);
    chk("ignored_rsp_instret", instret, 64'd0);

    // Instruction after reset counts from zero again.
    push_exp(5'd2, 32'h00000077, 1'b1, 1'b1, 1'b0);
    drive(32'h0, 32'h77, 5'd2, 1'b1, 2'b00, 3'b000);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected outputs never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
